// File: rtl/xy_index_bank.sv
// Bank of NUM_REGS index registers behind one command port: load from acc/data,
// increment/decrement with wrap or saturate, per-register zero flags and one-cycle status pulses.
module xy_index_bank #(
  parameter int WIDTH    = 16,
  parameter int NUM_REGS = 2,
  parameter int SEL_W    = 1,
  parameter int SATURATE = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      acc_op,
  input  logic                      load,
  input  logic                      inc,
  input  logic                      dec,
  input  logic [WIDTH-1:0]          acc_val,
  input  logic [WIDTH-1:0]          data_val,
  output logic [NUM_REGS*WIDTH-1:0] out,
  output logic [NUM_REGS-1:0]       zero,
  output logic                      wrap,
  output logic                      sel_err
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  logic [WIDTH-1:0] regs_q   [NUM_REGS];
  logic [WIDTH-1:0] regs_nxt [NUM_REGS];
  logic [WIDTH-1:0] cur_val;
  logic [WIDTH-1:0] new_val;
  logic             any_cmd;
  logic             sel_ok;
  logic             wrap_nxt;
  int               sel_idx;

  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no path leaves one unassigned and no latch is inferred.
    sel_idx  = int'(sel);
    sel_ok   = sel_idx < NUM_REGS;
    any_cmd  = acc_op | load | inc | dec;
    cur_val  = '0;
    new_val  = '0;
    wrap_nxt = 1'b0;

    for (int i = 0; i < NUM_REGS; i++) begin
      if (i == sel_idx) cur_val = regs_q[i];
    end

    // Priority acc_op > load > inc > dec; lower strobes are ignored.
    new_val = cur_val;
    if (acc_op) begin
      new_val = acc_val;
    end else if (load) begin
      new_val = data_val;
    end else if (inc) begin
      if (cur_val == ALL_ONES) begin
        wrap_nxt = 1'b1;
        new_val  = (SATURATE != 0) ? ALL_ONES : '0;
      end else begin
        new_val = cur_val + WIDTH'(1);
      end
    end else if (dec) begin
      if (cur_val == '0) begin
        wrap_nxt = 1'b1;
        new_val  = (SATURATE != 0) ? '0 : ALL_ONES;
      end else begin
        new_val = cur_val - WIDTH'(1);
      end
    end

    for (int i = 0; i < NUM_REGS; i++) begin
      regs_nxt[i] = (any_cmd && sel_ok && i == sel_idx) ? new_val : regs_q[i];
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every register samples pre-edge values, independent of statement order.
    if (reset) begin
      // NOTE: the register array is small and its contents are architecturally visible, so it is reset like any other flop.
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      zero    <= '1;
      wrap    <= 1'b0;
      sel_err <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_nxt[i];
        zero[i]   <= (regs_nxt[i] == '0);
      end
      wrap    <= any_cmd && sel_ok && wrap_nxt;
      sel_err <= any_cmd && !sel_ok;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign out[g*WIDTH +: WIDTH] = regs_q[g];
  end

endmodule

// File: tb/tb_xy_index_bank.sv
// Drives three configurations of xy_index_bank from one command stream and checks
// them against an arithmetic reference model; directed steps first, then random commands.
module tb_xy_index_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic        acc_op, load, inc, dec;
  logic [1:0]  sel;
  logic [15:0] acc_val, data_val;

  logic [31:0] out_a;  logic [1:0] zero_a;  logic wrap_a, err_a;
  logic [31:0] out_b;  logic [3:0] zero_b;  logic wrap_b, err_b;
  logic [47:0] out_c;  logic [2:0] zero_c;  logic wrap_c, err_c;

  always #5 clk = ~clk;

  // A: default wrap bank; B: 8-bit saturating, 4 regs; C: 3 regs so sel=3 is out of range.
  xy_index_bank #(.WIDTH(16), .NUM_REGS(2), .SEL_W(1), .SATURATE(0)) dut_a (
    .clk(clk), .reset(reset), .sel(sel[0:0]), .acc_op(acc_op), .load(load), .inc(inc), .dec(dec),
    .acc_val(acc_val), .data_val(data_val), .out(out_a), .zero(zero_a), .wrap(wrap_a), .sel_err(err_a));

  xy_index_bank #(.WIDTH(8), .NUM_REGS(4), .SEL_W(2), .SATURATE(1)) dut_b (
    .clk(clk), .reset(reset), .sel(sel), .acc_op(acc_op), .load(load), .inc(inc), .dec(dec),
    .acc_val(acc_val[7:0]), .data_val(data_val[7:0]), .out(out_b), .zero(zero_b), .wrap(wrap_b), .sel_err(err_b));

  xy_index_bank #(.WIDTH(16), .NUM_REGS(3), .SEL_W(2), .SATURATE(0)) dut_c (
    .clk(clk), .reset(reset), .sel(sel), .acc_op(acc_op), .load(load), .inc(inc), .dec(dec),
    .acc_val(acc_val), .data_val(data_val), .out(out_c), .zero(zero_c), .wrap(wrap_c), .sel_err(err_c));

  int cfg_w   [3] = '{16, 8, 16};
  int cfg_n   [3] = '{2, 4, 3};
  int cfg_sat [3] = '{0, 1, 0};

  longint mdl_reg [3][4];
  bit     mdl_wrap [3];
  bit     mdl_err  [3];

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] dut_reg(int d, int i);
    case (d)
      0:       return out_a[i*16 +: 16];
      1:       return {8'h00, out_b[i*8 +: 8]};
      default: return out_c[i*16 +: 16];
    endcase
  endfunction

  function automatic logic dut_zero(int d, int i);
    case (d)
      0:       return zero_a[i];
      1:       return zero_b[i];
      default: return zero_c[i];
    endcase
  endfunction

  function automatic logic dut_wrap(int d);
    return (d == 0) ? wrap_a : (d == 1) ? wrap_b : wrap_c;
  endfunction

  function automatic logic dut_err(int d);
    return (d == 0) ? err_a : (d == 1) ? err_b : err_c;
  endfunction

  // Reference: the register file as plain integers; overflow detected by leaving [0, 2**W - 1].
  task automatic model_update(int d);
    longint maxv = (longint'(1) << cfg_w[d]) - 1;
    int s = (d == 0) ? int'(sel[0]) : int'(sel);
    longint v;
    mdl_wrap[d] = 1'b0;
    mdl_err[d]  = 1'b0;
    if (reset) begin
      for (int i = 0; i < 4; i++) mdl_reg[d][i] = 0;
      return;
    end
    if (!(acc_op || load || inc || dec)) return;
    if (s >= cfg_n[d]) begin
      mdl_err[d] = 1'b1;
      return;
    end
    v = mdl_reg[d][s];
    if (acc_op)    v = longint'(acc_val) & maxv;
    else if (load) v = longint'(data_val) & maxv;
    else if (inc) begin
      v = v + 1;
      if (v > maxv) begin mdl_wrap[d] = 1'b1; v = cfg_sat[d] ? maxv : 0; end
    end else begin
      v = v - 1;
      if (v < 0) begin mdl_wrap[d] = 1'b1; v = cfg_sat[d] ? 0 : maxv; end
    end
    mdl_reg[d][s] = v;
  endtask

  task automatic check_all();
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < cfg_n[d]; i++) begin
        check($sformatf("d%0d_reg%0d", d, i), 64'(dut_reg(d, i)), 64'(mdl_reg[d][i]));
        check($sformatf("d%0d_zero%0d", d, i), 64'(dut_zero(d, i)), 64'(mdl_reg[d][i] == 0));
      end
      check($sformatf("d%0d_wrap", d), 64'(dut_wrap(d)), 64'(mdl_wrap[d]));
      check($sformatf("d%0d_sel_err", d), 64'(dut_err(d)), 64'(mdl_err[d]));
    end
  endtask

  task automatic step(bit a, bit l, bit i, bit d, logic [1:0] s,
                      logic [15:0] av, logic [15:0] dv, bit rst);
    acc_op = a; load = l; inc = i; dec = d; sel = s;
    acc_val = av; data_val = dv; reset = rst;
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_update(k);
    #1;
    check_all();
  endtask

  function automatic logic [15:0] pick_val();
    case ($urandom_range(0, 4))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h00FF;
      3:       return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    reset = 1'b1; acc_op = 1'b0; load = 1'b0; inc = 1'b0; dec = 1'b0;
    sel = '0; acc_val = '0; data_val = '0;
    for (int d = 0; d < 3; d++) for (int i = 0; i < 4; i++) mdl_reg[d][i] = 0;
    #2;

    // Reset beats a simultaneous load.
    step(1, 0, 0, 0, 2'd0, 16'h0002, 16'h0000, 1);
    step(1, 0, 0, 0, 2'd0, 16'h0002, 16'h0000, 1);
    check("rst_out_a", 64'(out_a), 64'h0);
    check("rst_zero_a", 64'(zero_a), 64'h3);

    // Loads.
    step(1, 0, 0, 0, 2'd0, 16'h0002, 16'h0000, 0);
    check("acc_x", 64'(out_a[15:0]), 64'h0002);
    check("acc_zero", 64'(zero_a), 64'h2);
    step(0, 1, 0, 0, 2'd1, 16'h0000, 16'h0001, 0);
    check("load_y", 64'(out_a[31:16]), 64'h0001);
    check("load_x_hold", 64'(out_a[15:0]), 64'h0002);

    // Priority: acc_op wins over load and inc.
    step(1, 1, 1, 0, 2'd0, 16'h00AA, 16'h0055, 0);
    check("prio_x", 64'(out_a[15:0]), 64'h00AA);

    // Wrap round trip on register 0.
    step(0, 1, 0, 0, 2'd0, 16'h0000, 16'hFFFF, 0);
    step(0, 0, 1, 0, 2'd0, 16'h0000, 16'h0000, 0);
    check("inc_wrap_x", 64'(out_a[15:0]), 64'h0);
    check("inc_wrap_flag", 64'(wrap_a), 64'h1);
    step(0, 0, 0, 1, 2'd0, 16'h0000, 16'h0000, 0);
    check("dec_wrap_x", 64'(out_a[15:0]), 64'hFFFF);
    step(0, 0, 0, 0, 2'd0, 16'h0000, 16'h0000, 0);
    check("idle_wrap", 64'(wrap_a), 64'h0);

    // Saturation on register 2 of the 8-bit bank.
    step(0, 1, 0, 0, 2'd2, 16'h0000, 16'h00FF, 0);
    step(0, 0, 1, 0, 2'd2, 16'h0000, 16'h0000, 0);
    check("sat_hi", 64'(out_b[23:16]), 64'hFF);
    check("sat_hi_wrap", 64'(wrap_b), 64'h1);
    step(0, 1, 0, 0, 2'd2, 16'h0000, 16'h0000, 0);
    step(0, 0, 0, 1, 2'd2, 16'h0000, 16'h0000, 0);
    check("sat_lo", 64'(out_b[23:16]), 64'h00);
    check("sat_lo_wrap", 64'(wrap_b), 64'h1);

    // Out-of-range select on the 3-register bank, back to back then idle.
    step(0, 1, 0, 0, 2'd3, 16'h0000, 16'h1234, 0);
    check("range_err", 64'(err_c), 64'h1);
    step(0, 0, 1, 0, 2'd3, 16'h0000, 16'h0000, 0);
    step(0, 0, 0, 0, 2'd0, 16'h0000, 16'h0000, 0);
    check("range_err_drop", 64'(err_c), 64'h0);

    // Count to 5, reset mid-run with inc held, then inc executes after release.
    step(0, 1, 0, 0, 2'd0, 16'h0000, 16'h0000, 0);
    for (int k = 0; k < 5; k++) step(0, 0, 1, 0, 2'd0, 16'h0000, 16'h0000, 0);
    check("count5", 64'(out_c[15:0]), 64'h5);
    step(0, 0, 1, 0, 2'd0, 16'h0000, 16'h0000, 1);
    check("mid_rst", 64'(out_c[15:0]), 64'h0);
    step(0, 0, 1, 0, 2'd0, 16'h0000, 16'h0000, 0);
    check("post_rst_inc", 64'(out_c[15:0]), 64'h1);

    // A reset pulse between edges is ignored.
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    step(0, 0, 1, 0, 2'd0, 16'h0000, 16'h0000, 0);
    check("glitch_rst", 64'(out_c[15:0]), 64'h2);

    // Random command stream.
    for (int k = 0; k < 400; k++) begin
      logic [3:0] strobes;
      strobes = ($urandom_range(0, 5) == 0) ? 4'b0000 : 4'($urandom);
      step(strobes[0], strobes[1], strobes[2], strobes[3], 2'($urandom),
           pick_val(), pick_val(), $urandom_range(0, 49) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/xy_index_bank.md
# xy_index_bank

Parametrised successor to the single X/Y index register. It holds NUM_REGS index registers of WIDTH bits each, sharing one command port. Each register can be loaded from the accumulator or the data bus, or incremented/decremented in place, with wrap or saturate behaviour. It sits beside the accumulator and feeds address/index values to the datapath, with per-register zero flags and a one-cycle wrap indicator for loop control.

## Interface
- WIDTH, 16, bit width of each register and of acc_val/data_val
- NUM_REGS, 2, number of registers (index 0 = X, 1 = Y, ...); 2..16
- SEL_W, 1, width of sel; must satisfy 2**SEL_W >= NUM_REGS
- SATURATE, 0, 0 = inc/dec wrap modulo 2**WIDTH; 1 = clamp at all-ones/zero
- clk  input  1  rising-edge clock, sole clock domain
- reset  input  1  synchronous, active-high reset
- sel  input  SEL_W  target register for the current command
- acc_op  input  1  load target from acc_val
- load  input  1  load target from data_val
- inc  input  1  target := target + 1
- dec  input  1  target := target - 1
- acc_val  input  WIDTH  accumulator value
- data_val  input  WIDTH  data bus value
- out  output  NUM_REGS*WIDTH  all registers, flattened; register i at bits [i*WIDTH +: WIDTH]
- zero  output  NUM_REGS  bit i high when register i == 0 (registered)
- wrap  output  1  one-cycle pulse: previous command overflowed/underflowed (or clamped when SATURATE=1)
- sel_err  output  1  one-cycle pulse: previous command addressed sel >= NUM_REGS

## Operation
- Command priority when several strobes are high in one cycle: acc_op > load > inc > dec. Only the highest-priority command executes; the others are ignored.
- Only register sel changes; all other registers hold.
- No strobe high: all registers hold; wrap and sel_err drop to 0.
- Load commands (acc_op, load) never assert wrap.
- inc, SATURATE=0: all-ones -> 0 and wrap=1.
- inc, SATURATE=1: all-ones stays all-ones and wrap=1.
- dec, SATURATE=0: 0 -> all-ones and wrap=1.
- dec, SATURATE=1: 0 stays 0 and wrap=1.
- Arithmetic is unsigned, WIDTH bits. Carry/borrow beyond WIDTH is discarded except as the source of wrap.
- sel >= NUM_REGS with any strobe high: no register changes; sel_err=1 next cycle; wrap=0.
- zero reflects the registered contents. It is computed from the next-state value, so zero and out are coherent in the same cycle.
- Reset: all registers = 0, zero = all ones, wrap = 0, sel_err = 0. Reset overrides any command in the same cycle.

## Timing
- All outputs are registered and update only on the rising edge of clk. There is no combinational path from inputs to outputs.
- Command latency is 1 cycle: a command sampled at edge N is visible on out/zero/wrap/sel_err after edge N.
- wrap and sel_err are exactly one cycle wide per offending command. Back-to-back offending commands hold them high continuously.
- Back-to-back commands to the same register chain: each command uses the value written at the previous edge (e.g. inc, inc from 0 gives 2 after 2 edges).
- Reset asserted mid-sequence: the state is cleared at the next edge. The first command after reset deasserts executes on the following edge.
- Reset is sampled only at the clock edge. A reset pulse that does not span a rising edge has no effect.

## Test plan
- Reset: reset=1 with acc_op=1, acc_val=16'h0002 for 2 edges -> out=0, zero=2'b11, wrap=0, sel_err=0.
- Loads: sel=0, acc_op=1, acc_val=16'h0002 -> X=16'h0002, Y=0, zero=2'b10. Then sel=1, load=1, data_val=16'h0001 -> Y=16'h0001, X unchanged.
- Priority: sel=0, acc_op=1, load=1, inc=1, acc_val=16'h00AA, data_val=16'h0055 -> X=16'h00AA only.
- Wrap: SATURATE=0, X=16'hFFFF, inc -> X=0, zero[0]=1, wrap=1 for one cycle. Then dec -> X=16'hFFFF, wrap=1. Then idle -> wrap=0.
- Saturate instance (SATURATE=1, NUM_REGS=4, SEL_W=2, WIDTH=8): reg2=8'hFF, inc -> stays 8'hFF, wrap=1. reg2=0, dec -> stays 0, wrap=1.
- Range error and reset mid-run (NUM_REGS=3, SEL_W=2): sel=3, load=1 -> no change, sel_err=1 for one cycle. Then X counting by inc with reset raised at count 5 -> X=0 next edge; a command held through reset executes on the first edge after reset drops.
